// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: radix-4 shift-add over WIDTH/2 cycles with
// valid/ready handshakes on both sides and a synchronous abort (clr).
module mul_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] f,
    output logic               busy
);

    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = WIDTH + 2;
    localparam int FW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [FW-1:0]    acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [FW-1:0]    f_q, f_d;

    logic [WIDTH-1:0] y_sh_s;
    logic [1:0]       digit_s;
    logic [PW-1:0]    pp_s;
    logic [FW-1:0]    term_s;
    logic [FW-1:0]    sum_s;
    logic             last_s;

    // State register; reset forces IDLE asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One radix-4 step: partial product x*d placed at bit 2k
    always_comb begin
        y_sh_s  = y_q >> {k_q, 1'b0};
        digit_s = y_sh_s[1:0];
        pp_s    = {2'b00, x_q} * {{WIDTH{1'b0}}, digit_s};
        term_s  = FW'(pp_s) << {k_q, 1'b0};
        sum_s   = acc_q + term_s;
        last_s  = (k_q == KW'(N - 1));
    end

    // Next-state logic; clr overrides accept and the output handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clr)           state_d = IDLE;
                else if (in_valid) state_d = CALC;
                else               state_d = IDLE;
            end
            CALC: begin
                if (clr)         state_d = IDLE;
                else if (last_s) state_d = DONE;
                else             state_d = CALC;
            end
            DONE: begin
                if (clr)            state_d = IDLE;
                else if (out_ready) state_d = IDLE;
                else                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; f only moves on the final CALC edge
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        acc_d = acc_q;
        k_d   = k_q;
        f_d   = f_q;
        if (clr) begin
            acc_d = {FW{1'b0}};
            k_d   = {KW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_d   = x;
                        y_d   = y;
                        acc_d = {FW{1'b0}};
                        k_d   = {KW{1'b0}};
                    end else begin
                        x_d = x_q;
                    end
                end
                CALC: begin
                    acc_d = sum_s;
                    k_d   = k_q + KW'(1);
                    if (last_s) begin
                        f_d = sum_s;
                    end else begin
                        f_d = f_q;
                    end
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= {WIDTH{1'b0}};
            y_q   <= {WIDTH{1'b0}};
            acc_q <= {FW{1'b0}};
            k_q   <= {KW{1'b0}};
            f_q   <= {FW{1'b0}};
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            k_q   <= k_d;
            f_q   <= f_d;
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        f         = f_q;
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (WIDTH=8): directed corner cases plus
// random operands, checked against plain x*y and an N-cycle latency model.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               clr;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] f;
    logic               busy;

    int checks;
    int errors;
    logic [2*WIDTH-1:0] last_f;

    mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_f"}, 32'(f), 32'(last_f));
    endtask

    // Accept (a,b), run N CALC cycles with noise on ignored inputs, land in DONE
    task automatic run_to_done(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] exp_f;
        exp_f    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        chk("pre_accept_in_ready", 32'(in_ready), 32'd1);
        x        = a;
        y        = b;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            x         = WIDTH'($urandom);
            y         = WIDTH'($urandom);
            chk("calc_busy", 32'(busy), 32'd1);
            chk("calc_out_valid", 32'(out_valid), 32'd0);
            chk("calc_in_ready", 32'(in_ready), 32'd0);
            chk("calc_f_held", 32'(f), 32'(last_f));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        last_f    = exp_f;
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_f", 32'(f), 32'(exp_f));
        chk("done_in_ready", 32'(in_ready), 32'd0);
    endtask

    // Hold DONE with out_ready=0 for some cycles, then hand the product off
    task automatic finish(input int hold);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_f", 32'(f), 32'(last_f));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_idle("after_ack");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_f    = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        clr       = 1'b0;
        out_ready = 1'b0;

        #3;
        chk_idle("reset_no_clk");
        #9;
        rst_n = 1'b1;

        // First accept on the first rising edge after reset release
        run_to_done(8'h0D, 8'h0B);
        chk("basic_f", 32'(f), 32'h008F);
        finish(0);

        run_to_done(8'hFF, 8'hFF);
        chk("max_f", 32'(f), 32'hFE01);
        finish(0);
        run_to_done(8'h00, 8'hA5);
        finish(1);

        run_to_done(8'h80, 8'h02);
        chk("bp_f", 32'(f), 32'h0100);
        finish(5);

        // Abort in the second CALC cycle
        x = 8'h12; y = 8'h34; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < N + 1; i++) begin
            step();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_to_done(8'd3, 8'd5);
        chk("after_abort_f", 32'(f), 32'h000F);
        finish(0);

        // clr beats a simultaneous accept
        in_valid = 1'b1; clr = 1'b1; x = 8'h55; y = 8'h66;
        step();
        in_valid = 1'b0; clr = 1'b0;
        chk_idle("clr_vs_accept");

        // clr with out_ready in DONE, and clr alone in DONE
        run_to_done(8'h21, 8'h43);
        clr = 1'b1; out_ready = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b0;
        chk_idle("clr_vs_ack");
        run_to_done(8'h9C, 8'h07);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_idle("clr_in_done");

        // Asynchronous reset between edges mid-CALC
        x = 8'hC3; y = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        last_f = '0;
        chk_idle("async_reset");
        #1;
        rst_n = 1'b1;
        run_to_done(8'h07, 8'h09);
        finish(0);

        // Random operands and backpressure
        for (int t = 0; t < 30; t++) begin
            run_to_done(WIDTH'($urandom), WIDTH'($urandom));
            finish(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; it SHALL be even and at least 2.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: operands x and y are valid.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts operands.
REQ-007 Port x SHALL be an input, WIDTH bits: unsigned multiplicand.
REQ-008 Port y SHALL be an input, WIDTH bits: unsigned multiplier.
REQ-009 Port clr SHALL be an input, 1 bit: synchronous abort.
REQ-010 Port out_valid SHALL be an output, 1 bit: f holds a new product.
REQ-011 Port out_ready SHALL be an input, 1 bit: the consumer takes f.
REQ-012 Port f SHALL be an output, 2*WIDTH bits: unsigned product.
REQ-013 Port busy SHALL be an output, 1 bit: high when state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept: in IDLE with in_valid=1 and clr=0, the block SHALL latch x and y, clear the accumulator and digit counter, and move to CALC on the same edge.
REQ-017 Each CALC cycle SHALL process 2-bit digit d = y[2k+1:2k] for counter k, with k running from 0 to N-1 and N = WIDTH/2.
REQ-018 Each CALC cycle SHALL add (x*d) << 2k to a 2*WIDTH-bit accumulator; the partial product x*d is WIDTH+2 bits wide.
REQ-019 Overflow of the accumulator is impossible, and the accumulator SHALL NOT be truncated before the final result.
REQ-020 After the CALC edge with k=N-1, the state SHALL be DONE, f SHALL equal x*y and out_valid SHALL be 1, exactly N cycles after the accept edge.
REQ-021 The number of CALC cycles SHALL be fixed at N; there is no early termination for zero digits or zero operands.
REQ-022 In DONE with out_ready=1, the block SHALL return to IDLE on that edge, so in_ready=1 the next cycle.
REQ-023 In DONE with out_ready=0, out_valid and f SHALL hold stable.
REQ-024 f SHALL change only on entry to DONE and SHALL otherwise retain the last product.
REQ-025 Changes on x, y or in_valid during CALC or DONE SHALL be ignored.
REQ-026 clr=1 in any state SHALL force IDLE on the next edge, discard the accumulator, and leave f unchanged.
REQ-027 clr=1 SHALL take priority over a simultaneous accept or a simultaneous out_ready handshake.
REQ-028 In DONE, clr=1 with out_ready=0 SHALL drop out_valid without a handshake.
REQ-029 There SHALL be no combinational path from in_valid or out_ready to in_ready or out_valid; all outputs SHALL be registered or decoded from state only.
REQ-030 The back-to-back throughput SHALL be one product per N+2 cycles: accept, N CALC cycles, then DONE with out_ready=1, then IDLE.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with the accumulator, counter and f all 0.
REQ-032 While rst_n=0, the outputs SHALL be in_ready=1, out_valid=0 and busy=0, independent of clk.
REQ-033 Reset asserted during CALC or DONE SHALL abandon the operation immediately.
REQ-034 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=8, N=4)
REQ-035 Basic: x=0x0D, y=0x0B accepted at edge E0 -> out_valid rises after edge E0+4, f=0x008F, busy=1 during E0+1..E0+4.
REQ-036 Maximum: x=0xFF, y=0xFF -> f=0xFE01 after 4 CALC cycles; x=0x00, y=0xA5 -> f=0x0000, still 4 CALC cycles.
REQ-037 Backpressure: after x=0x80, y=0x02 completes, hold out_ready=0 for 5 cycles -> out_valid=1 and f=0x0100 stable, in_ready=0; set out_ready=1 -> IDLE next cycle.
REQ-038 Abort: clr=1 in the 2nd CALC cycle of x=0x12, y=0x34 -> IDLE next edge, out_valid never asserts, f keeps the previous product; the next operation x=3, y=5 gives f=0x000F.
REQ-039 Simultaneous events: in IDLE, in_valid=1 and clr=1 together -> no accept, in_ready stays 1; in DONE, out_ready=1 and clr=1 together -> IDLE, f unchanged.
REQ-040 Reset: rst_n=0 pulsed mid-CALC between edges -> immediately in_ready=1, out_valid=0, f=0; the operation is dropped.
